// File: rtl/uvmt_clk_st_clk_sched.sv
// Command-driven clock scheduler: derives a glitch-free divided clock (clk_o)
// from the reference clock under START / STOP / SET_HALF control.
module uvmt_clk_st_clk_sched #(
  parameter int DIV_W        = 8,
  parameter int DEFAULT_HALF = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DIV_W-1:0] cmd_half_per,
  output logic             clk_o,
  output logic             running,
  output logic             cmd_err,
  output logic [CNT_W-1:0] edge_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP_PEND
  } state_t;

  localparam logic [1:0]       OP_NOP   = 2'b00;
  localparam logic [1:0]       OP_START = 2'b01;
  localparam logic [1:0]       OP_STOP  = 2'b10;
  localparam logic [1:0]       OP_SET   = 2'b11;
  localparam logic [DIV_W-1:0] ONE_D    = DIV_W'(1);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [DIV_W-1:0] HALF_RST = DIV_W'(DEFAULT_HALF);

  state_t           state;
  state_t           next_state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] half_q;
  logic [DIV_W-1:0] pend_val;
  logic             pend;

  logic accept;
  logic is_start;
  logic is_stop;
  logic is_set;
  logic is_nop;
  logic set_ok;
  logic illegal;
  logic tick;
  logic rise;
  logic fall;
  logic stop_now;

  assign accept   = cmd_valid && cmd_ready;
  assign is_nop   = accept && (cmd_op == OP_NOP);
  assign is_start = accept && (cmd_op == OP_START);
  assign is_stop  = accept && (cmd_op == OP_STOP);
  assign is_set   = accept && (cmd_op == OP_SET);
  assign set_ok   = is_set && (cmd_half_per != '0);
  assign illegal  = (is_stop && (state == IDLE))
                 || (is_start && (state != IDLE))
                 || (is_set && (cmd_half_per == '0));

  // A phase ends when the counter reaches half_q-1; a stop while low
  // pre-empts that edge so clk_o never starts a high phase it cannot finish.
  assign tick     = (state != IDLE) && (cnt == (half_q - ONE_D));
  assign rise     = tick && !clk_o;
  assign fall     = tick && clk_o;
  assign stop_now = (state == RUN) && is_stop && !clk_o;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (is_start) next_state = RUN;
      end
      RUN: begin
        if (is_stop) begin
          if (!clk_o || fall) next_state = IDLE;
          else                next_state = STOP_PEND;
        end
      end
      STOP_PEND: begin
        if (fall) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    running   = (state != IDLE);
    cmd_ready = !pend && (state != STOP_PEND);
  end

  // Pending half-period loads only on a falling edge, so the new value
  // always starts with a fresh low phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_o    <= 1'b0;
      cnt      <= '0;
      half_q   <= HALF_RST;
      pend     <= 1'b0;
      pend_val <= '0;
      edge_cnt <= '0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= illegal;
      if (state == IDLE) begin
        cnt <= '0;
        if (is_start) edge_cnt <= '0;
        if (set_ok) half_q <= cmd_half_per;
      end else if (stop_now) begin
        cnt <= '0;
      end else begin
        if (tick) begin
          cnt   <= '0;
          clk_o <= ~clk_o;
          if (rise && (edge_cnt != '1)) edge_cnt <= edge_cnt + ONE_C;
          if (fall && pend) begin
            half_q <= pend_val;
            pend   <= 1'b0;
          end
        end else begin
          cnt <= cnt + ONE_D;
        end
        if (set_ok) begin
          pend     <= 1'b1;
          pend_val <= cmd_half_per;
        end
      end
    end
  end

endmodule

// File: tb/tb_uvmt_clk_st_clk_sched.sv
// Self-checking bench for uvmt_clk_st_clk_sched: directed scenarios with
// literal expectations, then random commands against a time-based model.
module tb_uvmt_clk_st_clk_sched;

  localparam int DIV_W        = 8;
  localparam int DEFAULT_HALF = 4;
  localparam int CNT_W        = 4;
  localparam int EMAX         = (1 << CNT_W) - 1;

  localparam bit [1:0] NOP   = 2'b00;
  localparam bit [1:0] START = 2'b01;
  localparam bit [1:0] STOP  = 2'b10;
  localparam bit [1:0] SETH  = 2'b11;

  logic             clk;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [DIV_W-1:0] cmd_half_per;
  logic             clk_o;
  logic             running;
  logic             cmd_err;
  logic [CNT_W-1:0] edge_cnt;

  int total;
  int bad;
  bit check_en;

  // Model: the running clock is described by its level and the absolute
  // cycle at which the current phase ends.
  int t;
  bit m_run;
  bit m_stop_pend;
  bit m_clk;
  int m_half;
  int m_next_toggle;
  bit m_pend;
  int m_pend_val;
  int m_edges;
  bit m_err;

  uvmt_clk_st_clk_sched #(
    .DIV_W(DIV_W),
    .DEFAULT_HALF(DEFAULT_HALF),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_half_per(cmd_half_per),
    .clk_o(clk_o),
    .running(running),
    .cmd_err(cmd_err),
    .edge_cnt(edge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_run       = 1'b0;
    m_stop_pend = 1'b0;
    m_clk       = 1'b0;
    m_half      = DEFAULT_HALF;
    m_next_toggle = 0;
    m_pend      = 1'b0;
    m_pend_val  = 0;
    m_edges     = 0;
    m_err       = 1'b0;
  endtask

  task automatic modelStep(input bit v, input bit [1:0] op, input int hp);
    bit acc, tog, old_run, old_clk, stop_now;
    t++;
    old_run  = m_run;
    old_clk  = m_clk;
    acc      = v && !m_pend && !m_stop_pend;
    tog      = m_run && (t == m_next_toggle);
    stop_now = acc && (op == STOP) && old_run && !old_clk;
    m_err    = 1'b0;
    if (tog && !stop_now) begin
      if (!m_clk) begin
        m_clk = 1'b1;
        if (m_edges < EMAX) m_edges++;
      end else begin
        m_clk = 1'b0;
        if (m_pend) begin
          m_half = m_pend_val;
          m_pend = 1'b0;
        end
        if (m_stop_pend) begin
          m_run       = 1'b0;
          m_stop_pend = 1'b0;
        end
      end
      m_next_toggle = t + m_half;
    end
    if (acc) begin
      case (op)
        START: begin
          if (old_run) m_err = 1'b1;
          else begin
            m_run         = 1'b1;
            m_clk         = 1'b0;
            m_edges       = 0;
            m_next_toggle = t + m_half;
          end
        end
        STOP: begin
          if (!old_run)     m_err = 1'b1;
          else if (!old_clk) m_run = 1'b0;
          else if (tog)      m_run = 1'b0;
          else               m_stop_pend = 1'b1;
        end
        SETH: begin
          if (hp == 0)      m_err = 1'b1;
          else if (!old_run) m_half = hp;
          else begin
            m_pend     = 1'b1;
            m_pend_val = hp;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input bit v, input bit [1:0] op, input int hp);
    cmd_valid    = v;
    cmd_op       = op;
    cmd_half_per = DIV_W'(hp);
    @(posedge clk);
    modelStep(v, op, hp);
    #1;
    cmd_valid    = 1'b0;
    cmd_op       = NOP;
    cmd_half_per = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, NOP, 0);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("clk_o", int'(clk_o), int'(m_clk));
      checkOutput("running", int'(running), int'(m_run));
      checkOutput("cmd_ready", int'(cmd_ready), int'(!m_pend && !m_stop_pend));
      checkOutput("cmd_err", int'(cmd_err), int'(m_err));
      checkOutput("edge_cnt", int'(edge_cnt), m_edges);
    end
  end

  initial begin
    total        = 0;
    bad          = 0;
    check_en     = 1'b0;
    t            = 0;
    reset_n      = 1'b0;
    cmd_valid    = 1'b0;
    cmd_op       = NOP;
    cmd_half_per = '0;
    modelReset();
    #12;
    checkOutput("rst_clk_o", int'(clk_o), 0);
    checkOutput("rst_running", int'(running), 0);
    checkOutput("rst_ready", int'(cmd_ready), 1);
    checkOutput("rst_err", int'(cmd_err), 0);
    checkOutput("rst_edge_cnt", int'(edge_cnt), 0);
    @(negedge clk);
    reset_n  = 1'b1;
    check_en = 1'b1;

    // Start with the reset half-period of 4
    applyStimulus(1'b1, START, 0);
    checkOutput("t1_running", int'(running), 1);
    idle(3);  checkOutput("t1_k3_clk", int'(clk_o), 0);
    idle(1);  checkOutput("t1_k4_clk", int'(clk_o), 1);
    checkOutput("t1_k4_edges", int'(edge_cnt), 1);
    idle(3);  checkOutput("t1_k7_clk", int'(clk_o), 1);
    idle(1);  checkOutput("t1_k8_clk", int'(clk_o), 0);
    idle(68); checkOutput("t1_k76_clk", int'(clk_o), 1);
    checkOutput("t1_k76_edges", int'(edge_cnt), 10);

    // Period change requested one cycle into a high phase
    applyStimulus(1'b1, SETH, 2);
    checkOutput("t2_ready_low", int'(cmd_ready), 0);
    idle(2);  checkOutput("t2_k79_clk", int'(clk_o), 1);
    checkOutput("t2_k79_ready", int'(cmd_ready), 0);
    idle(1);  checkOutput("t2_k80_clk", int'(clk_o), 0);
    checkOutput("t2_k80_ready", int'(cmd_ready), 1);
    idle(1);  checkOutput("t2_k81_clk", int'(clk_o), 0);
    idle(1);  checkOutput("t2_k82_clk", int'(clk_o), 1);
    idle(2);  checkOutput("t2_k84_clk", int'(clk_o), 0);

    // Back to half 4, then STOP one cycle into the high phase
    applyStimulus(1'b1, SETH, 4);
    idle(6);  checkOutput("t3_k91_clk", int'(clk_o), 0);
    idle(1);  checkOutput("t3_k92_clk", int'(clk_o), 1);
    applyStimulus(1'b1, STOP, 0);
    checkOutput("t3_pend_ready", int'(cmd_ready), 0);
    checkOutput("t3_pend_running", int'(running), 1);
    idle(2);  checkOutput("t3_k95_clk", int'(clk_o), 1);
    idle(1);  checkOutput("t3_k96_clk", int'(clk_o), 0);
    checkOutput("t3_k96_running", int'(running), 0);
    checkOutput("t3_k96_ready", int'(cmd_ready), 1);
    applyStimulus(1'b1, START, 0);
    idle(1);
    applyStimulus(1'b1, STOP, 0);
    checkOutput("t3_lowstop_running", int'(running), 0);
    idle(3);  checkOutput("t3_lowstop_clk", int'(clk_o), 0);

    // Illegal commands
    applyStimulus(1'b1, STOP, 0);
    checkOutput("t4_stop_idle_err", int'(cmd_err), 1);
    idle(1);  checkOutput("t4_err_clear", int'(cmd_err), 0);
    applyStimulus(1'b1, START, 0);
    idle(1);
    applyStimulus(1'b1, START, 0);
    checkOutput("t4_start_run_err", int'(cmd_err), 1);
    idle(1);  checkOutput("t4_k3_err", int'(cmd_err), 0);
    idle(1);  checkOutput("t4_k4_clk", int'(clk_o), 1);
    applyStimulus(1'b1, SETH, 0);
    checkOutput("t4_set0_err", int'(cmd_err), 1);
    checkOutput("t4_set0_ready", int'(cmd_ready), 1);
    idle(2);  checkOutput("t4_k7_clk", int'(clk_o), 1);
    idle(1);  checkOutput("t4_k8_clk", int'(clk_o), 0);
    applyStimulus(1'b1, STOP, 0);

    // Half of 1 and edge counter saturation
    applyStimulus(1'b1, SETH, 1);
    applyStimulus(1'b1, START, 0);
    idle(1);  checkOutput("t5_k1_clk", int'(clk_o), 1);
    idle(1);  checkOutput("t5_k2_clk", int'(clk_o), 0);
    idle(38); checkOutput("t5_sat", int'(edge_cnt), 15);
    applyStimulus(1'b1, STOP, 0);
    checkOutput("t5_hold", int'(edge_cnt), 15);
    applyStimulus(1'b1, START, 0);
    checkOutput("t5_restart", int'(edge_cnt), 0);
    applyStimulus(1'b1, STOP, 0);

    // Asynchronous reset mid-high-phase with a pending period change
    applyStimulus(1'b1, SETH, 3);
    applyStimulus(1'b1, START, 0);
    idle(3);
    applyStimulus(1'b1, SETH, 5);
    checkOutput("t6_pend_ready", int'(cmd_ready), 0);
    checkOutput("t6_pre_clk", int'(clk_o), 1);
    #2;
    check_en = 1'b0;
    reset_n  = 1'b0;
    #1;
    checkOutput("t6_rst_clk", int'(clk_o), 0);
    checkOutput("t6_rst_ready", int'(cmd_ready), 1);
    checkOutput("t6_rst_running", int'(running), 0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    check_en = 1'b1;
    applyStimulus(1'b1, START, 0);
    idle(3);  checkOutput("t6_k3_clk", int'(clk_o), 0);
    idle(1);  checkOutput("t6_k4_clk", int'(clk_o), 1);

    // Random command traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 4) == 0, 2'($urandom % 4), int'($urandom_range(0, 5)));
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
